// File: rtl/bias_add_stream.sv
// bias_add_stream
//   Consumer end of the per-layer bias bus. Each of N_adder_tree lanes takes an
//   18-bit adder-tree partial result, adds the matching bias lane, saturates the
//   sum to 18 bits and optionally clamps negatives to zero (RELU). Results leave
//   on a two-stage valid/ready pipeline together with a last-pixel flag that
//   marks the final transfer of each PIXELS-long feature map.
//
// Ports
//   clk        single clock
//   rst        synchronous active-high reset
//   bias       packed bias bus, lane i = bias[18*(i+1)-1:18*i], static per layer
//   in_data    packed adder-tree results, same packing
//   in_valid   in_data valid
//   in_ready   block can accept in_data this cycle
//   out_data   packed biased (saturated, optionally rectified) results
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data
//   out_last   high with the final pixel of a feature map
module bias_add_stream #(
    parameter int N_adder_tree = 16,
    parameter bit RELU         = 1'b1,
    parameter int PIXELS       = 784
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_adder_tree*18-1:0] bias,
    input  logic [N_adder_tree*18-1:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [N_adder_tree*18-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last
);

    localparam int W  = 18;
    localparam int CW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(PIXELS - 1);

    logic [W:0]                s1_sum [N_adder_tree];
    logic                      s1_valid;
    logic                      s2_valid;
    logic [CW-1:0]             pix_cnt;
    logic [N_adder_tree*W-1:0] sat_data;
    logic [W:0]                lane_sum;
    logic [W-1:0]              lane_res;
    logic                      adv1;
    logic                      adv2;
    logic                      at_last;

    // Each stage advances when it is empty or the stage after it drains; the
    // ready path never looks at in_valid.
    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;
    assign at_last   = (pix_cnt == LAST_CNT);

    // Saturation: the 19-bit sum overflows 18 bits exactly when its top two
    // bits disagree; the top bit then gives the direction of the clamp.
    always_comb begin
        sat_data = '0;
        lane_sum = '0;
        lane_res = '0;
        for (int unsigned i = 0; i < N_adder_tree; i++) begin
            lane_sum = s1_sum[i];
            if (lane_sum[W] != lane_sum[W-1])
                lane_res = lane_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            else
                lane_res = lane_sum[W-1:0];
            if (RELU && lane_res[W-1])
                lane_res = '0;
            sat_data[i*W +: W] = lane_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
            pix_cnt  <= '0;
            for (int unsigned i = 0; i < N_adder_tree; i++)
                s1_sum[i] <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    for (int unsigned i = 0; i < N_adder_tree; i++)
                        s1_sum[i] <= {in_data[i*W+W-1], in_data[i*W +: W]}
                                   + {bias[i*W+W-1], bias[i*W +: W]};
                end
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                // The pixel count follows s1->s2 loads so out_last rides with
                // the data it describes.
                if (s1_valid) begin
                    out_data <= sat_data;
                    out_last <= at_last;
                    pix_cnt  <= at_last ? '0 : pix_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bias_add_stream.sv
// tb_bias_add_stream
//   Two instances share one stimulus stream: u_lin (RELU=0, PIXELS=4) and
//   u_relu (RELU=1, PIXELS=5). Accepted beats push expected results into a
//   scoreboard queue; a monitor pops and compares on every output transfer.
module tb_bias_add_stream;

    localparam int N  = 16;
    localparam int W  = 18;
    localparam int BW = N * W;
    localparam int PA = 4;
    localparam int PB = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] bias = '0;
    logic [BW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;

    logic          in_ready_a, in_ready_b;
    logic [BW-1:0] out_data_a, out_data_b;
    logic          out_valid_a, out_valid_b;
    logic          out_last_a, out_last_b;

    bias_add_stream #(.N_adder_tree(N), .RELU(1'b0), .PIXELS(PA)) u_lin (
        .clk(clk), .rst(rst), .bias(bias), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_last(out_last_a)
    );

    bias_add_stream #(.N_adder_tree(N), .RELU(1'b1), .PIXELS(PB)) u_relu (
        .clk(clk), .rst(rst), .bias(bias), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_last(out_last_b)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [BW-1:0] da;
        logic [BW-1:0] db;
        logic          la;
        logic          lb;
        int unsigned   acyc;
        bit            lat;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   acc_idx = 0;
    bit   lat_mode = 1'b0;
    bit   bp_mode = 1'b0;
    bit   rand_ready = 1'b0;
    int   bp_cnt = 0;

    int tin[6]   = '{131000, -131072, -100, -5000, 5000, -131000};
    int tbias[6] = '{500, -1, 100, 200, -200, -500};

    // Reference: plain integer add, clamp to the 18-bit signed range, rectify.
    function automatic logic [BW-1:0] model(input logic [BW-1:0] d,
                                            input logic [BW-1:0] b,
                                            input bit relu);
        logic [BW-1:0] r = '0;
        for (int i = 0; i < N; i++) begin
            logic signed [W-1:0] x;
            logic signed [W-1:0] y;
            int s;
            x = d[i*W +: W];
            y = b[i*W +: W];
            s = int'(x) + int'(y);
            if (s > 131071) s = 131071;
            else if (s < -131072) s = -131072;
            if (relu && s < 0) s = 0;
            r[i*W +: W] = s[W-1:0];
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] rnd_bus();
        logic [BW-1:0] r = '0;
        logic [W-1:0]  v;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(3))
                0: v = W'($urandom);
                1: v = 18'h1FFFF - W'($urandom_range(2000));
                2: v = 18'h20000 + W'($urandom_range(2000));
                default: v = W'($urandom_range(4000)) - 18'd2000;
            endcase
            r[i*W +: W] = v;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // One clock: note acceptance before the edge, then update out_ready after it.
    task automatic step(output bit acc);
        exp_t e;
        @(negedge clk);
        #1;
        acc = in_valid && in_ready_a && !rst;
        if (acc) begin
            e.da   = model(in_data, bias, 1'b0);
            e.db   = model(in_data, bias, 1'b1);
            e.la   = (acc_idx % PA) == PA - 1;
            e.lb   = (acc_idx % PB) == PB - 1;
            e.acyc = cyc;
            e.lat  = lat_mode;
            q.push_back(e);
            acc_idx++;
        end
        @(posedge clk);
        #1;
        if (bp_mode) begin
            bp_cnt++;
            out_ready = !(bp_cnt >= 3 && bp_cnt <= 8);
        end else if (rand_ready) begin
            out_ready = ($urandom_range(3) != 0);
        end
    endtask

    task automatic send(input logic [BW-1:0] d);
        bit acc = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            step(acc);
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) step(acc);
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 200 && q.size() != 0; k++) step(acc);
        chk("drain_left", q.size(), 0);
    endtask

    // Monitor: ready model, hold-while-stalled, and scoreboard pops.
    logic [BW-1:0] pd;
    logic          pl;
    bit            pstall = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("in_ready_a", in_ready_a, (q.size() < 2) || out_ready);
            chk("in_ready_b", in_ready_b, (q.size() < 2) || out_ready);
            if (pstall) begin
                chk("hold_valid", out_valid_a, 1'b1);
                chk("hold_data", out_data_a, pd);
                chk("hold_last", out_last_a, pl);
            end
            if (out_valid_a && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_out: got data %0h with no beat expected", out_data_a);
                end else begin
                    e = q.pop_front();
                    chk("valid_b", out_valid_b, 1'b1);
                    chk("data_lin", out_data_a, e.da);
                    chk("data_relu", out_data_b, e.db);
                    chk("last_lin", out_last_a, e.la);
                    chk("last_relu", out_last_b, e.lb);
                    if (e.lat) chk("latency", cyc - e.acyc, 2);
                end
            end
        end
        pstall = !rst && out_valid_a && !out_ready;
        pd     = out_data_a;
        pl     = out_last_a;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] d;
        bit acc;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid_a", out_valid_a, 1'b0);
        chk("rst_valid_b", out_valid_b, 1'b0);
        chk("rst_data_a", out_data_a, '0);
        chk("rst_last_a", out_last_a, 1'b0);
        chk("rst_ready_a", in_ready_a, 1'b1);
        @(posedge clk);
        #1;

        // Continuous stream, lane0 = 1000 + (-300), other lanes random.
        lat_mode = 1'b1;
        out_ready = 1'b1;
        bias = rnd_bus();
        bias[0 +: W] = W'(-300);
        for (int k = 0; k < 20; k++) begin
            d = rnd_bus();
            if (k == 0) d[0 +: W] = W'(1000);
            send(d);
        end
        drain();

        // Directed saturation / rectification corners in lanes 0-5.
        bias = rnd_bus();
        for (int i = 0; i < 6; i++) bias[i*W +: W] = W'(tbias[i]);
        d = rnd_bus();
        for (int i = 0; i < 6; i++) d[i*W +: W] = W'(tin[i]);
        send(d);
        for (int k = 0; k < 15; k++) send(rnd_bus());
        drain();
        lat_mode = 1'b0;

        // Backpressure: out_ready low for stream cycles 3-8.
        bias = rnd_bus();
        bp_cnt = 0;
        bp_mode = 1'b1;
        for (int k = 0; k < 10; k++) send(rnd_bus());
        bp_mode = 1'b0;
        out_ready = 1'b1;
        drain();

        // Random valid and ready.
        rand_ready = 1'b1;
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(3) != 0) send(rnd_bus());
            else idle(1);
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with two beats buffered: both dropped, count restarts at 0.
        out_ready = 1'b0;
        send(rnd_bus());
        send(rnd_bus());
        rst = 1'b1;
        q.delete();
        acc_idx = 0;
        step(acc);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid_a", out_valid_a, 1'b0);
        chk("post_rst_valid_b", out_valid_b, 1'b0);
        chk("post_rst_last_a", out_last_a, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        lat_mode = 1'b1;
        for (int k = 0; k < 6; k++) send(rnd_bus());
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bias_add_stream.md
Name: bias_add_stream

Overview:
- Consumer end of the per-layer bias constant bus.
- Takes N_adder_tree lanes of 18-bit adder-tree partial results and adds the matching lane of the packed bias bus, saturating each sum to 18 bits. Optionally applies ReLU.
- Results leave on a valid/ready stream as a 2-stage pipeline.
- Counts output pixels and flags the last pixel of a feature map so the downstream layer buffer can close the map.

Parameters:
- N_adder_tree, 16, number of parallel lanes (one output channel per lane).
- RELU, 1, 1 = clamp negative results to 0 after saturation; 0 = pass signed result.
- PIXELS, 784, number of output transfers per feature map (28x28); last-flag period.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- bias  in  N_adder_tree*18  packed bias bus, lane i = bias[18*(i+1)-1:18*i], two's complement, static.
- in_data  in  N_adder_tree*18  packed adder-tree results, same lane packing, two's complement.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept in_data this cycle.
- out_data  out  N_adder_tree*18  packed biased results.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_last  out  1  high with the final pixel of a feature map.

Behaviour:
- Reset: rst sampled on rising clk. When high, all of the following clear in that cycle:
  - s1_valid, s2_valid, out_valid = 0.
  - out_data = 0, out_last = 0, pixel counter = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
- Reset mid-operation discards all in-flight data with no output transfer.
- Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Stage 1 (s1):
  - Per lane, 19-bit sum = sext(in_data lane) + sext(bias lane), registered with s1_valid.
  - Bias is sampled combinationally at input acceptance. Bias changes only between layers.
- Stage 2 (s2):
  - Saturate: sum > 131071 -> 131071 (18'h1FFFF); sum < -131072 -> -131072 (18'h20000); otherwise the low 18 bits.
  - If RELU=1, a negative saturated value becomes 0.
  - Result is registered to out_data with out_valid = s2_valid.
- Flow control:
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1, combinational from registered state and out_ready. No path from in_valid to in_ready.
  - s2 loads from s1 on adv2. If s1 is empty at that point, s2_valid goes to 0.
  - s1 loads input on adv1. With no input transfer, s1_valid goes to 0 when adv1.
  - While out_valid && !out_ready: out_data and out_last hold stable, no data is lost, and the pipeline buffers at most 2 beats before deasserting in_ready.
- Latency: a beat accepted in cycle t appears on out_valid in cycle t+2 when not stalled. Full throughput is 1 beat/cycle.
- Pixel counter:
  - Counts s1->s2 loads, modulo PIXELS.
  - The out_last bit is computed alongside the data and registered with it: set when counter == PIXELS-1 at load.
  - The counter wraps to 0 at that load and the next beat starts a new map.
  - Count width = clog2(PIXELS).
- Simultaneous events: input and output transfer in the same cycle with both stages full is legal; both stages shift.
- rst has priority over all transfers.

Test Plan:
- RELU=0, lane0 in=1000, bias=-300, continuous valid, out_ready=1 -> out lane0=700 exactly 2 cycles after acceptance; all 16 lanes independently correct against a model with random bias.
- Saturation, RELU=0: in=131000, bias=500 -> 131071. In=-131072, bias=-1 -> -131072. In=-100, bias=100 -> 0.
- RELU=1: in=-5000, bias=200 -> 0. In=5000, bias=-200 -> 4800. Saturating negative -> 0.
- Backpressure: stream 10 beats, out_ready low for cycles 3-8 -> in_ready drops after 2 beats are buffered, out_data is stable while stalled, all 10 beats arrive in order with none duplicated.
- PIXELS=4: stream 9 beats -> out_last high on beats 4 and 8 only, including when a stall lands on beat 4.
- Assert rst with 2 beats in flight -> out_valid=0 next cycle, beats dropped, counter=0; the first post-reset beat's out_last follows the count from 0.
